// File: rtl/ising_pkg.sv
// Shared types and helpers for the Ising anneal run controller.
package ising_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETTLE,
    RUN,
    SAMPLE,
    DONE
  } state_t;

  // Cycles from the oscillator reset falling to the phase capture.
  localparam int SAMPLE_CYCLES = 3;

  function automatic int addr_width(input int n);
    return (n * n > 1) ? $clog2(n * n) : 1;
  endfunction

  function automatic logic [31:0] centre_weight(input int nw);
    return 32'(1) << (nw / 2);
  endfunction

  function automatic logic [31:0] weight_mask(input int nw);
    return (nw >= 32) ? '1 : ((32'(1) << nw) - 32'(1));
  endfunction

endpackage

// File: rtl/ising_run_ctrl_if.sv
// Bundle of control, weight-stream, array and phase signals around ising_run_ctrl.
interface ising_run_ctrl_if import ising_pkg::*; #(
  parameter int N      = 8,
  parameter int ADDR_W = addr_width(N)
);

  logic              start;
  logic [31:0]       run_cycles;
  logic              w_valid;
  logic [31:0]       w_data;
  logic              w_ready;
  logic              cell_wready;
  logic [ADDR_W-1:0] cell_addr;
  logic [31:0]       cell_wdata;
  logic              ising_rstn;
  logic [N-1:0]      phase_in;
  logic [N-1:0]      phase_out;
  logic              busy;
  logic              done;
  logic              wt_err;

  modport master (
    output start, run_cycles, w_valid, w_data, phase_in,
    input  w_ready, cell_wready, cell_addr, cell_wdata, ising_rstn,
           phase_out, busy, done, wt_err
  );

  modport slave (
    input  start, run_cycles, w_valid, w_data, phase_in,
    output w_ready, cell_wready, cell_addr, cell_wdata, ising_rstn,
           phase_out, busy, done, wt_err
  );

endinterface

// File: rtl/ising_phase_sync.sv
// N-wide two-flop synchroniser for the asynchronous oscillator phase outputs.
module ising_phase_sync #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         i_rstn,
  input  logic [N-1:0] i_d,
  output logic [N-1:0] o_q
);

  logic [N-1:0] r_meta;
  logic [N-1:0] r_sync;

  always_ff @(posedge clk) begin
    if (!i_rstn) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/ising_run_ctrl.sv
// Sequences one anneal run: weight load, settle, oscillate, phase capture.
// Optional one-hot weight check enabled by defining ISING_WEIGHT_CHECK_EN.
module ising_run_ctrl import ising_pkg::*; #(
  parameter int N             = 8,
  parameter int NUM_WEIGHTS   = 15,
  parameter int ADDR_W        = addr_width(N),
  parameter int SETTLE_CYCLES = 4
) (
  input  logic            clk,
  input  logic            axi_rstn,
  ising_run_ctrl_if.slave bus
);

  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(N * N - 1);

  if ((NUM_WEIGHTS % 2) == 0 || NUM_WEIGHTS > 32) begin : g_param_check
    $error("NUM_WEIGHTS must be odd and at most 32");
  end

  state_t            r_state;
  state_t            w_state_next;
  logic [31:0]       r_cnt;
  logic [31:0]       r_run_len;
  logic [ADDR_W-1:0] r_index;
  logic              r_cell_wready;
  logic [ADDR_W-1:0] r_cell_addr;
  logic [31:0]       r_cell_wdata;
  logic [N-1:0]      r_phase_out;
  logic [N-1:0]      w_phase_sync;
  logic              w_hs;
  logic              w_start_ok;
  logic [31:0]       w_word;

  assign w_hs       = (r_state == LOAD) && bus.w_valid;
  assign w_start_ok = bus.start && ((r_state == IDLE) || (r_state == DONE));

`ifdef ISING_WEIGHT_CHECK_EN
  logic [NUM_WEIGHTS-1:0] w_field;
  logic                   w_wt_bad;
  logic                   r_wt_err;

  // Valid word: exactly one bit set in the weight field, nothing above it.
  assign w_field  = bus.w_data[NUM_WEIGHTS-1:0];
  assign w_wt_bad = (w_field == '0) ||
                    ((w_field & (w_field - NUM_WEIGHTS'(1))) != '0) ||
                    ((bus.w_data & ~weight_mask(NUM_WEIGHTS)) != '0);
  assign w_word   = w_wt_bad ? centre_weight(NUM_WEIGHTS) : bus.w_data;

  always_ff @(posedge clk) begin
    if (!axi_rstn) begin
      r_wt_err <= 1'b0;
    end else if (w_start_ok) begin
      r_wt_err <= 1'b0;
    end else if (w_hs && w_wt_bad) begin
      r_wt_err <= 1'b1;
    end
  end

  assign bus.wt_err = r_wt_err;
`else
  assign w_word     = bus.w_data;
  assign bus.wt_err = 1'b0;
`endif

  ising_phase_sync #(.N(N)) u_phase_sync (
    .clk    (clk),
    .i_rstn (axi_rstn),
    .i_d    (bus.phase_in),
    .o_q    (w_phase_sync)
  );

  always_ff @(posedge clk) begin
    if (!axi_rstn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_state_next = LOAD;
      LOAD:    if (w_hs && (r_index == LAST_CELL)) w_state_next = SETTLE;
      SETTLE:  if (r_cnt == 32'(SETTLE_CYCLES - 1)) w_state_next = RUN;
      RUN:     if (r_cnt == '0) w_state_next = SAMPLE;
      SAMPLE:  if (r_cnt == 32'(SAMPLE_CYCLES - 1)) w_state_next = DONE;
      DONE:    if (bus.start) w_state_next = LOAD;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!axi_rstn) begin
      r_cnt         <= '0;
      r_run_len     <= '0;
      r_index       <= '0;
      r_cell_wready <= 1'b0;
      r_cell_addr   <= '0;
      r_cell_wdata  <= '0;
      r_phase_out   <= '0;
    end else begin
      r_cell_wready <= w_hs;
      if (w_hs) begin
        r_cell_addr  <= r_index;
        r_cell_wdata <= w_word;
        if (r_index != LAST_CELL) r_index <= r_index + ADDR_W'(1);
      end
      if (w_start_ok) begin
        r_run_len <= bus.run_cycles;
        r_index   <= '0;
      end

      // One counter serves SETTLE (up), RUN (down to 0) and SAMPLE (up).
      case (r_state)
        SETTLE: begin
          if (w_state_next == RUN) r_cnt <= (r_run_len == '0) ? '0 : r_run_len - 32'(1);
          else                     r_cnt <= r_cnt + 32'(1);
        end
        RUN:    r_cnt <= (r_cnt == '0) ? '0 : r_cnt - 32'(1);
        SAMPLE: begin
          if (w_state_next == DONE) begin
            r_phase_out <= w_phase_sync;
            r_cnt       <= '0;
          end else begin
            r_cnt <= r_cnt + 32'(1);
          end
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  assign bus.w_ready     = (r_state == LOAD);
  assign bus.cell_wready = r_cell_wready;
  assign bus.cell_addr   = r_cell_addr;
  assign bus.cell_wdata  = r_cell_wdata;
  assign bus.ising_rstn  = (r_state == RUN);
  assign bus.phase_out   = r_phase_out;
  assign bus.busy        = (r_state != IDLE) && (r_state != DONE);
  assign bus.done        = (r_state == DONE);

endmodule

// File: tb/tb_ising_run_ctrl.sv
// Randomised scoreboard bench for ising_run_ctrl on a 2x2 array.
module tb_ising_run_ctrl;

  localparam int N      = 2;
  localparam int NW     = 15;
  localparam int AW     = 2;
  localparam int SETTLE = 4;

  logic clk = 1'b0;
  logic axi_rstn = 1'b0;
  always #5 clk = ~clk;

  ising_run_ctrl_if #(.N(N), .ADDR_W(AW)) bus ();

  ising_run_ctrl #(
    .N(N), .NUM_WEIGHTS(NW), .ADDR_W(AW), .SETTLE_CYCLES(SETTLE)
  ) dut (
    .clk      (clk),
    .axi_rstn (axi_rstn),
    .bus      (bus)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } strobe_t;

  typedef struct {
    int           rstn_len;
    logic [N-1:0] phase;
    logic         wt_err;
  } run_t;

  strobe_t strobe_q[$];
  run_t    run_q[$];
  strobe_t se;
  run_t    re;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0]  words[4];
  logic [N-1:0] last_phase = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference rules for the weight word seen by the array.
  function automatic bit word_ok(input logic [31:0] w);
    return ($countones(w[NW-1:0]) == 1) && ((w >> NW) == 0);
  endfunction

  function automatic logic [31:0] expect_word(input logic [31:0] w);
`ifdef ISING_WEIGHT_CHECK_EN
    return word_ok(w) ? w : (32'h1 << (NW / 2));
`else
    return w;
`endif
  endfunction

  function automatic logic [31:0] rand_word();
    int sel;
    sel = $urandom_range(3, 0);
    case (sel)
      0:       return $urandom & 32'h0000_7fff;
      1:       return (32'h1 << $urandom_range(NW - 1, 0)) | (32'h1 << $urandom_range(31, NW));
      default: return 32'h1 << $urandom_range(NW - 1, 0);
    endcase
  endfunction

  // Monitor: consumes expectations whenever the DUT strobes or completes.
  int cyc = 0, hi_cnt = 0, hi_len = 0, last_strobe_cyc = 0, fall_cyc = 0;
  bit prev_rstn = 0, prev_done = 0;

  always @(negedge clk) begin
    cyc++;
    if (axi_rstn) begin
      if (bus.cell_wready) begin
        if (strobe_q.size() == 0) begin
          check("unexpected_strobe", 1, 0);
        end else begin
          se = strobe_q.pop_front();
          check("cell_addr", bus.cell_addr, se.addr);
          check("cell_wdata", bus.cell_wdata, se.data);
        end
        last_strobe_cyc = cyc;
      end
      if (bus.ising_rstn && !prev_rstn) check("settle_gap", cyc - last_strobe_cyc, SETTLE);
      if (bus.ising_rstn) hi_cnt++;
      if (!bus.ising_rstn && prev_rstn) begin
        hi_len   = hi_cnt;
        hi_cnt   = 0;
        fall_cyc = cyc;
      end
      if (bus.done && !prev_done) begin
        if (run_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          re = run_q.pop_front();
          check("rstn_high_cycles", hi_len, re.rstn_len);
          check("done_latency", cyc - fall_cyc, 3);
          check("phase_out", bus.phase_out, re.phase);
          check("wt_err", bus.wt_err, re.wt_err);
        end
      end
    end else begin
      hi_cnt = 0;
    end
    prev_rstn = bus.ising_rstn;
    prev_done = bus.done;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_once(input logic [31:0] rc, input logic [N-1:0] ph,
                          input bit gaps, input bit junk_start, input bit abort);
    bit model_err = 0;
    int t;
    bus.phase_in = ph;
    bus.start = 1'b1;
    bus.run_cycles = rc;
    tick();
    bus.start = 1'b0;
    bus.run_cycles = $urandom;
    check("busy_after_start", bus.busy, 1);
    check("w_ready_in_load", bus.w_ready, 1);
    check("wt_err_after_start", bus.wt_err, 0);
    check("phase_held_after_start", bus.phase_out, last_phase);
    for (int k = 0; k < 4; k++) begin
      if (gaps) begin
        bus.w_valid = 1'b0;
        tick();
      end
      if (junk_start && k == 2) begin
        bus.start = 1'b1;
        bus.run_cycles = rc + 7;
      end
      bus.w_valid = 1'b1;
      bus.w_data = words[k];
      strobe_q.push_back('{addr: AW'(k), data: expect_word(words[k])});
      if (!word_ok(words[k])) model_err = 1;
      t = 0;
      while (!bus.w_ready && t < 20) begin
        tick();
        t++;
      end
      if (t >= 20) check("w_ready_timeout", 0, 1);
      tick();
      bus.start = 1'b0;
      bus.run_cycles = $urandom;
    end
    bus.w_valid = 1'b0;
    bus.w_data = $urandom;
    check("w_ready_after_last", bus.w_ready, 0);
`ifdef ISING_WEIGHT_CHECK_EN
    run_q.push_back('{rstn_len: (rc == 0) ? 1 : int'(rc), phase: ph, wt_err: model_err});
`else
    run_q.push_back('{rstn_len: (rc == 0) ? 1 : int'(rc), phase: ph, wt_err: 1'b0});
`endif
    if (abort) begin
      t = 0;
      while (!bus.ising_rstn && t < 50) begin
        tick();
        t++;
      end
      if (t >= 50) check("rstn_rise_timeout", 0, 1);
      repeat (4) tick();
      axi_rstn = 1'b0;
      tick();
      check("abort_rstn", bus.ising_rstn, 0);
      check("abort_busy", bus.busy, 0);
      check("abort_done", bus.done, 0);
      check("abort_phase", bus.phase_out, 0);
      run_q.delete();
      last_phase = '0;
      axi_rstn = 1'b1;
      tick();
    end else begin
      t = 0;
      while (!bus.done && t < 200) begin
        tick();
        t++;
      end
      if (t >= 200) check("done_timeout", 0, 1);
      last_phase = ph;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0;
    bus.run_cycles = '0;
    bus.w_valid = 1'b0;
    bus.w_data = '0;
    bus.phase_in = '0;
    axi_rstn = 1'b0;
    repeat (3) tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("rst_w_ready", bus.w_ready, 0);
    check("rst_cell_wready", bus.cell_wready, 0);
    check("rst_cell_addr", bus.cell_addr, 0);
    check("rst_cell_wdata", bus.cell_wdata, 0);
    check("rst_ising_rstn", bus.ising_rstn, 0);
    check("rst_phase_out", bus.phase_out, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_wt_err", bus.wt_err, 0);
    axi_rstn = 1'b1;
    tick();
    check("idle_after_rst", bus.busy, 0);

    for (int k = 0; k < 4; k++) words[k] = 32'h0000_0080;
    run_once(10, 2'b10, 0, 0, 0);
    for (int k = 0; k < 4; k++) words[k] = 32'h1 << $urandom_range(NW - 1, 0);
    run_once($urandom_range(12, 1), 2'($urandom), 1, 0, 0);
    run_once(20, 2'b01, 1, 0, 1);
    run_once(5, 2'b11, 1, 1, 0);
    words[1] = 32'h0000_0003;
    run_once(0, 2'b10, 0, 0, 0);
    for (int k = 0; k < 4; k++) words[k] = 32'h1 << $urandom_range(NW - 1, 0);
    run_once(3, 2'b01, 0, 0, 0);
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < 4; k++) words[k] = rand_word();
      run_once($urandom_range(15, 0), 2'($urandom), 1'($urandom), 1'($urandom), 0);
    end

    repeat (5) tick();
    check("strobe_queue_drained", strobe_q.size(), 0);
    check("run_queue_drained", run_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
